// File: rtl/cnn_pkg.sv
// ============================================================================
// cnn_pkg : shared kernel geometry, weight types and scheduler state encoding
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_pkg;

  localparam int KERNEL_TAPS  = 9;
  localparam int WEIGHT_WIDTH = 8;

  typedef logic signed [WEIGHT_WIDTH-1:0] weight_t;
  typedef weight_t [KERNEL_TAPS-1:0]      kernel_wt_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sched_state_e;

  // Index width for a filter count; a single filter still needs one bit.
  function automatic int fw_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_tag_pipe.sv
// ============================================================================
// conv_tag_pipe : fixed-depth shift register carrying {valid, idx, last} tags
//                 alongside the MAC pipeline
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_last,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_last,
  output logic             o_any
);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_last;
  logic [IDX_W-1:0] r_idx [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_last  <= '0;
      for (int s = 0; s < DEPTH; s++) r_idx[s] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_last[0]  <= i_last;
      r_idx[0]   <= i_idx;
      for (int s = 1; s < DEPTH; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_last[s]  <= r_last[s-1];
        r_idx[s]   <= r_idx[s-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_last  = r_last[DEPTH-1];
  assign o_idx   = r_idx[DEPTH-1];
  assign o_any   = |r_valid;

endmodule

`default_nettype wire

// File: rtl/conv_filter_sched.sv
// ============================================================================
// conv_filter_sched : replays each accepted 3x3 window to one shared MAC once
//                     per filter and tags the returning results
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_filter_sched
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int OUT_WIDTH   = 32,
  parameter int NUM_FILTERS = 4,
  parameter int MAC_LATENCY = 2,
  localparam int FW         = fw_of(NUM_FILTERS)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_enable,
  input  logic                                 i_wt_we,
  input  logic [FW-1:0]                        i_wt_filt,
  input  logic [3:0]                           i_wt_tap,
  input  logic [WEIGHT_WIDTH-1:0]              i_wt_data,
  output logic                                 o_wt_err,
  input  logic                                 i_win_valid,
  output logic                                 o_win_ready,
  input  logic [KERNEL_TAPS*DATA_WIDTH-1:0]    i_window,
  output logic                                 o_mac_valid,
  output logic [KERNEL_TAPS*DATA_WIDTH-1:0]    o_mac_window,
  output logic [KERNEL_TAPS*WEIGHT_WIDTH-1:0]  o_mac_weights,
  input  logic                                 i_mac_valid,
  input  logic [OUT_WIDTH-1:0]                 i_mac_result,
  output logic                                 o_valid,
  output logic [OUT_WIDTH-1:0]                 o_result,
  output logic [FW-1:0]                        o_filt_idx,
  output logic                                 o_last,
  output logic                                 o_busy,
  output logic                                 o_seq_err
);

  localparam logic [0:0]    c_st_idle  = IDLE;
  localparam logic [0:0]    c_st_issue = ISSUE;
  localparam logic [FW-1:0] c_last_cnt = FW'(NUM_FILTERS - 1);

  logic [0:0]                        r_state;
  logic [FW-1:0]                     r_cnt;
  logic [KERNEL_TAPS*DATA_WIDTH-1:0] r_window;
  kernel_wt_t                        r_bank [NUM_FILTERS];

  logic                 r_valid;
  logic [OUT_WIDTH-1:0] r_result;
  logic [FW-1:0]        r_filt_idx;
  logic                 r_last;
  logic                 r_seq_err;
  logic                 r_wt_err;

  logic          w_issue;
  logic          w_cnt_last;
  logic          w_hs;
  logic          w_wt_addr_ok;
  logic          w_wt_accept;
  logic          w_tag_valid;
  logic [FW-1:0] w_tag_idx;
  logic          w_tag_last;
  logic          w_tag_any;

  assign w_issue    = (r_state == c_st_issue);
  assign w_cnt_last = (r_cnt == c_last_cnt);

  // A new window may only land on the final filter slot so the MAC never idles.
  assign o_win_ready = i_enable && (!w_issue || w_cnt_last);
  assign w_hs        = i_win_valid && o_win_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_st_idle;
      r_cnt    <= '0;
      r_window <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_hs) begin
            r_window <= i_window;
            r_cnt    <= '0;
            r_state  <= c_st_issue;
          end
        end
        c_st_issue: begin
          if (!w_cnt_last) begin
            r_cnt <= r_cnt + FW'(1);
          end else if (w_hs) begin
            r_window <= i_window;
            r_cnt    <= '0;
          end else begin
            r_cnt   <= '0;
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign w_wt_addr_ok = (i_wt_tap < 4'(KERNEL_TAPS)) &&
                        ({1'b0, i_wt_filt} < (FW+1)'(NUM_FILTERS));
  assign w_wt_accept  = i_wt_we && !o_busy && !w_hs && w_wt_addr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < NUM_FILTERS; f++) r_bank[f] <= '0;
    end else begin
      for (int f = 0; f < NUM_FILTERS; f++)
        for (int t = 0; t < KERNEL_TAPS; t++)
          if (w_wt_accept && i_wt_filt == FW'(f) && i_wt_tap == 4'(t))
            r_bank[f][t] <= weight_t'(i_wt_data);
    end
  end

  assign o_mac_valid   = w_issue;
  assign o_mac_window  = r_window;
  assign o_mac_weights = r_bank[r_cnt];

  conv_tag_pipe #(
    .DEPTH (MAC_LATENCY),
    .IDX_W (FW)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_issue),
    .i_idx   (r_cnt),
    .i_last  (w_cnt_last),
    .o_valid (w_tag_valid),
    .o_idx   (w_tag_idx),
    .o_last  (w_tag_last),
    .o_any   (w_tag_any)
  );

  assign o_busy = w_issue || w_tag_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_result   <= '0;
      r_filt_idx <= '0;
      r_last     <= 1'b0;
      r_seq_err  <= 1'b0;
      r_wt_err   <= 1'b0;
    end else begin
      r_valid  <= i_mac_valid && w_tag_valid;
      r_wt_err <= i_wt_we && !w_wt_accept;
      if (i_mac_valid && w_tag_valid) begin
        r_result   <= i_mac_result;
        r_filt_idx <= w_tag_idx;
        r_last     <= w_tag_last;
      end
      if (i_mac_valid && !w_tag_valid) r_seq_err <= 1'b1;
    end
  end

  assign o_valid    = r_valid;
  assign o_result   = r_result;
  assign o_filt_idx = r_filt_idx;
  assign o_last     = r_last;
  assign o_seq_err  = r_seq_err;
  assign o_wt_err   = r_wt_err;

endmodule

`default_nettype wire

// File: tb/tb_conv_filter_sched.sv
// ============================================================================
// tb_conv_filter_sched : directed bench with a 2-cycle behavioural MAC model
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_conv_filter_sched;
  import cnn_pkg::*;

  localparam int DW = 8;
  localparam int OW = 32;
  localparam int NF = 4;
  localparam int ML = 2;
  localparam int FW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_enable, i_wt_we, i_win_valid, i_mac_valid;
  logic [FW-1:0]   i_wt_filt;
  logic [3:0]      i_wt_tap;
  logic [7:0]      i_wt_data;
  logic [9*DW-1:0] i_window;
  logic [OW-1:0]   i_mac_result;
  logic            o_wt_err, o_win_ready, o_mac_valid, o_valid, o_last, o_busy, o_seq_err;
  logic [9*DW-1:0] o_mac_window;
  logic [71:0]     o_mac_weights;
  logic [OW-1:0]   o_result;
  logic [FW-1:0]   o_filt_idx;

  conv_filter_sched #(
    .DATA_WIDTH (DW), .OUT_WIDTH (OW), .NUM_FILTERS (NF), .MAC_LATENCY (ML)
  ) dut (
    .clk (clk), .rst_n (rst_n), .i_enable (i_enable),
    .i_wt_we (i_wt_we), .i_wt_filt (i_wt_filt), .i_wt_tap (i_wt_tap),
    .i_wt_data (i_wt_data), .o_wt_err (o_wt_err),
    .i_win_valid (i_win_valid), .o_win_ready (o_win_ready), .i_window (i_window),
    .o_mac_valid (o_mac_valid), .o_mac_window (o_mac_window),
    .o_mac_weights (o_mac_weights), .i_mac_valid (i_mac_valid),
    .i_mac_result (i_mac_result), .o_valid (o_valid), .o_result (o_result),
    .o_filt_idx (o_filt_idx), .o_last (o_last), .o_busy (o_busy),
    .o_seq_err (o_seq_err)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] dot(input logic [9*DW-1:0] w, input logic [71:0] k);
    int acc;
    acc = 0;
    for (int t = 0; t < 9; t++)
      acc += int'(w[t*DW +: DW]) * int'($signed(k[t*8 +: 8]));
    return OW'(acc);
  endfunction

  function automatic logic [9*DW-1:0] mkwin(input logic [7:0] p);
    return {9{p}};
  endfunction

  // Behavioural MAC: two register stages, result appears two cycles after o_mac_valid.
  logic          r_m1v, r_m2v, r_inject;
  logic [OW-1:0] r_m1r, r_m2r;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m1v <= 1'b0; r_m2v <= 1'b0; r_m1r <= '0; r_m2r <= '0;
    end else begin
      r_m1v <= o_mac_valid;
      r_m1r <= dot(o_mac_window, o_mac_weights);
      r_m2v <= r_m1v;
      r_m2r <= r_m1r;
    end
  end
  assign i_mac_valid  = r_m2v | r_inject;
  assign i_mac_result = r_m2r;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OW-1:0] res;
    logic [FW-1:0] idx;
    logic          last;
    int            c;
  } rec_t;

  rec_t res_q[$];
  int   mac_q[$];
  int   last_fall = 0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    if (o_valid) res_q.push_back('{o_result, o_filt_idx, o_last, cyc});
    if (o_mac_valid) mac_q.push_back(cyc);
    if (prev_busy && !o_busy) last_fall = cyc;
    prev_busy = o_busy;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((o_busy || o_valid) && n < 60);
    if (o_busy || o_valid) check_val("idle_timeout", 72'd0, 72'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_window(input logic [9*DW-1:0] w);
    int n;
    n = 0;
    @(negedge clk);
    i_window = w; i_win_valid = 1'b1; i_enable = 1'b1;
    #1;
    while (!o_win_ready && n < 40) begin
      @(negedge clk); #1; n++;
    end
    if (!o_win_ready) check_val("ready_timeout", 72'd0, 72'd1);
    @(negedge clk);
    i_win_valid = 1'b0;
  endtask

  task automatic wt_write(input logic [FW-1:0] f, input logic [3:0] t,
                          input logic [7:0] d, input logic exp_err);
    @(negedge clk);
    i_wt_we = 1'b1; i_wt_filt = f; i_wt_tap = t; i_wt_data = d;
    @(negedge clk);
    i_wt_we = 1'b0;
    check_val("wt_err", {71'd0, o_wt_err}, {71'd0, exp_err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rb, mb, hs, n, sum, lasts;
    int rdy_c[$];
    logic [71:0] e1;

    i_enable = 0; i_wt_we = 0; i_wt_filt = '0; i_wt_tap = '0; i_wt_data = '0;
    i_win_valid = 0; i_window = '0; r_inject = 0;
    repeat (3) @(negedge clk);
    check_val("rst_ready",   o_win_ready, 0);
    check_val("rst_macv",    o_mac_valid, 0);
    check_val("rst_valid",   o_valid, 0);
    check_val("rst_busy",    o_busy, 0);
    check_val("rst_seqerr",  o_seq_err, 0);
    check_val("rst_wterr",   o_wt_err, 0);
    check_val("rst_result",  o_result, 0);
    check_val("rst_weights", o_mac_weights, 0);
    rst_n = 1'b1;

    // Filter k weights all k+1, except filter 2 which gets 1..9 by tap.
    for (int f = 0; f < NF; f++)
      for (int t = 0; t < 9; t++)
        wt_write(FW'(f), 4'(t), (f == 2) ? 8'(t + 1) : 8'(f + 1), 1'b0);

    // Weight readback during cnt=2
    rb = res_q.size(); mb = mac_q.size();
    send_window(mkwin(8'd10));
    #1;
    check_val("t1_macv",   o_mac_valid, 1);
    check_val("t1_window", o_mac_window, mkwin(8'd10));
    check_val("t1_ready_issue", o_win_ready, 0);
    repeat (2) @(negedge clk);
    #1;
    for (int t = 0; t < 9; t++) e1[t*8 +: 8] = 8'(t + 1);
    check_val("t1_weights", o_mac_weights, e1);
    wait_idle();
    check_val("t1_nres", res_q.size() - rb, 4);
    if (res_q.size() >= rb + 4) check_val("t1_res2", res_q[rb+2].res, 450);

    // Uniform filters: 90/180/270/360
    for (int t = 0; t < 9; t++) wt_write(2'd2, 4'(t), 8'd3, 1'b0);
    rb = res_q.size(); mb = mac_q.size();
    send_window(mkwin(8'd10));
    wait_idle();
    check_val("t2_nres", res_q.size() - rb, 4);
    if (res_q.size() >= rb + 4) begin
      for (int k = 0; k < 4; k++) begin
        check_val($sformatf("t2_res%0d", k),  res_q[rb+k].res, 90 * (k + 1));
        check_val($sformatf("t2_idx%0d", k),  res_q[rb+k].idx, k);
        check_val($sformatf("t2_last%0d", k), res_q[rb+k].last, (k == 3) ? 1 : 0);
      end
      check_val("t2_latency", res_q[rb].c - mac_q[mb], 3);
    end

    // Three back-to-back windows with i_win_valid held high
    rb = res_q.size(); mb = mac_q.size();
    hs = 0; n = 0;
    @(negedge clk);
    i_enable = 1; i_win_valid = 1; i_window = mkwin(8'd1);
    while (hs < 3 && n < 60) begin
      #1;
      if (o_win_ready) begin
        rdy_c.push_back(cyc);
        hs++;
      end
      @(negedge clk);
      n++;
      i_window = mkwin(8'(hs + 1));
      if (hs == 3) i_win_valid = 0;
    end
    wait_idle();
    check_val("t3_nhs", rdy_c.size(), 3);
    if (rdy_c.size() == 3) begin
      check_val("t3_gap1", rdy_c[1] - rdy_c[0], 4);
      check_val("t3_gap2", rdy_c[2] - rdy_c[1], 4);
    end
    check_val("t3_nmac", mac_q.size() - mb, 12);
    if (mac_q.size() >= mb + 12) check_val("t3_contig", mac_q[mb+11] - mac_q[mb], 11);
    check_val("t3_nres", res_q.size() - rb, 12);
    sum = 0; lasts = 0;
    for (int i = rb; i < res_q.size(); i++) begin
      sum += int'(res_q[i].res);
      lasts += int'(res_q[i].last);
    end
    check_val("t3_sum", sum, 540);
    check_val("t3_lasts", lasts, 3);

    // Writes dropped in handshake cycle, while busy, and with tap 9
    rb = res_q.size();
    @(negedge clk);
    i_enable = 1; i_window = mkwin(8'd5); i_win_valid = 1;
    i_wt_we = 1; i_wt_filt = 2'd0; i_wt_tap = 4'd0; i_wt_data = 8'd100;
    @(negedge clk);
    i_win_valid = 0;
    #1;
    check_val("t4_issue", o_mac_valid, 1);
    check_val("t4_err_hs", o_wt_err, 1);
    @(negedge clk);
    i_wt_we = 0;
    check_val("t4_err_busy", o_wt_err, 1);
    @(negedge clk);
    check_val("t4_err_pulse", o_wt_err, 0);
    wait_idle();
    check_val("t4_nres", res_q.size() - rb, 4);
    if (res_q.size() >= rb + 4) begin
      check_val("t4_res0", res_q[rb].res, 45);
      check_val("t4_res3", res_q[rb+3].res, 180);
    end
    wt_write(2'd1, 4'd9, 8'h55, 1'b1);

    // Drop i_enable on the second ISSUE cycle
    rb = res_q.size(); mb = mac_q.size();
    @(negedge clk);
    i_window = mkwin(8'd7); i_win_valid = 1; i_enable = 1;
    @(negedge clk);
    @(negedge clk);
    i_enable = 0;
    repeat (10) @(negedge clk);
    check_val("t5_nmac", mac_q.size() - mb, 4);
    check_val("t5_nres", res_q.size() - rb, 4);
    check_val("t5_idle", o_busy, 0);
    if (res_q.size() >= rb + 4) begin
      check_val("t5_res1", res_q[rb+1].res, 126);
      check_val("t5_res3", res_q[rb+3].res, 252);
      check_val("t5_last3", res_q[rb+3].last, 1);
    end
    if (mac_q.size() >= mb + 4) check_val("t5_busy_fall", last_fall - mac_q[mb+3], 3);
    i_win_valid = 0;

    // Reset mid-ISSUE, then a spurious MAC result
    send_window(mkwin(8'd3));
    i_enable = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    rb = res_q.size();
    check_val("t6_busy_rst", o_busy, 0);
    check_val("t6_macv_rst", o_mac_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    check_val("t6_valid", o_valid, 0);
    check_val("t6_seq0", o_seq_err, 0);
    check_val("t6_result", o_result, 0);
    check_val("t6_busy", o_busy, 0);
    check_val("t6_weights", o_mac_weights, 0);
    r_inject = 1;
    @(negedge clk);
    r_inject = 0;
    check_val("t6_seq1", o_seq_err, 1);
    check_val("t6_novalid", o_valid, 0);
    @(negedge clk);
    check_val("t6_seq_sticky", o_seq_err, 1);
    check_val("t6_nres", res_q.size() - rb, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
